// File: rtl/password_entry_ctrl.sv
// Keypad scanner, debouncer and lock state machine feeding the display driver.
// Digits are debounced per 4-column sweep; function buttons act on their rising edge.
module password_entry_ctrl #(
  parameter int SCAN_TICKS   = 200_000,
  parameter int HOLD_TICKS   = 100_000_000,
  parameter int FREEZE_TICKS = 500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        key_set,
  input  logic        key_confirm,
  input  logic        key_clear,
  output logic [11:0] password_input,
  output logic [2:0]  input_count,
  output logic        success_input,
  output logic [2:0]  current_work_state,
  output logic [1:0]  failure_times
);

  typedef enum logic [2:0] {
    IDLE              = 3'b000,
    SETTING_CODE      = 3'b001,
    SETCODE_FINISH    = 3'b010,
    INPUTING_PASSWORD = 3'b011,
    MATCH_SUCCESS     = 3'b100,
    FREEZED           = 3'b101
  } state_t;

  localparam logic [31:0] SCAN_LAST   = 32'(SCAN_TICKS - 1);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_TICKS - 1);
  localparam logic [31:0] FREEZE_LAST = 32'(FREEZE_TICKS - 1);

  state_t      state_r;
  logic [31:0] scan_cnt_r;
  logic [1:0]  col_idx_r;
  logic        sweep_hit_r;
  logic [3:0]  sweep_code_r;
  logic        prev_hit_r;
  logic [3:0]  prev_code_r;
  logic        locked_r;
  logic [11:0] stored_pw_r;
  logic        pw_valid_r;
  logic [31:0] timer_r;
  logic        set_q_r;
  logic        confirm_q_r;
  logic        clear_q_r;

  logic [2:0]  row_dec_s;
  logic        sample_s;
  logic        sweep_end_s;
  logic        cur_hit_s;
  logic [3:0]  cur_code_s;
  logic        end_hit_s;
  logic [3:0]  end_code_s;
  logic        digit_ok_s;
  logic        release_s;
  logic        set_edge_s;
  logic        confirm_edge_s;
  logic        clear_edge_s;
  logic [11:0] buf_next_s;
  logic        can_write_s;

  // Returns {hit, row index} for the lowest active-low row.
  function automatic logic [2:0] row_decode(input logic [3:0] rows);
    logic [2:0] res;
    if (rows[0] == 1'b0) begin
      res = 3'b100;
    end else if (rows[1] == 1'b0) begin
      res = 3'b101;
    end else if (rows[2] == 1'b0) begin
      res = 3'b110;
    end else if (rows[3] == 1'b0) begin
      res = 3'b111;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  assign current_work_state = state_r;

  // Sweep result, debounce decision, button edges and the next entry buffer.
  always_comb begin
    row_dec_s      = row_decode(row_in);
    sample_s       = (scan_cnt_r == SCAN_LAST);
    sweep_end_s    = sample_s && (col_idx_r == 2'd3);
    cur_hit_s      = sample_s && row_dec_s[2];
    cur_code_s     = {row_dec_s[1:0], col_idx_r};
    // The earliest column detected in a sweep owns the sweep.
    if (sweep_hit_r) begin
      end_hit_s  = 1'b1;
      end_code_s = sweep_code_r;
    end else begin
      end_hit_s  = cur_hit_s;
      end_code_s = cur_code_s;
    end
    digit_ok_s     = sweep_end_s && end_hit_s && prev_hit_r &&
                     (end_code_s == prev_code_r) && !locked_r;
    release_s      = sweep_end_s && !end_hit_s;
    set_edge_s     = key_set && !set_q_r;
    confirm_edge_s = key_confirm && !confirm_q_r;
    clear_edge_s   = key_clear && !clear_q_r;
    case (input_count)
      3'd0: begin
        buf_next_s  = {end_code_s, password_input[7:0]};
        can_write_s = 1'b1;
      end
      3'd1: begin
        buf_next_s  = {password_input[11:8], end_code_s, password_input[3:0]};
        can_write_s = 1'b1;
      end
      3'd2: begin
        buf_next_s  = {password_input[11:4], end_code_s};
        can_write_s = 1'b1;
      end
      default: begin
        buf_next_s  = password_input;
        can_write_s = 1'b0;
      end
    endcase
  end

  // Column scan and per-sweep debounce; runs in every lock state.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r   <= 32'd0;
      col_idx_r    <= 2'd0;
      col_out      <= 4'b1110;
      sweep_hit_r  <= 1'b0;
      sweep_code_r <= 4'h0;
      prev_hit_r   <= 1'b0;
      prev_code_r  <= 4'h0;
      locked_r     <= 1'b0;
    end else if (sample_s) begin
      scan_cnt_r <= 32'd0;
      col_idx_r  <= col_idx_r + 2'd1;
      col_out    <= {col_out[2:0], col_out[3]};
      if (sweep_end_s) begin
        sweep_hit_r  <= 1'b0;
        sweep_code_r <= 4'h0;
        prev_hit_r   <= end_hit_s;
        prev_code_r  <= end_code_s;
        if (!end_hit_s) begin
          locked_r <= 1'b0;
        end else if (digit_ok_s) begin
          locked_r <= 1'b1;
        end else begin
          locked_r <= locked_r;
        end
      end else if (cur_hit_s && !sweep_hit_r) begin
        sweep_hit_r  <= 1'b1;
        sweep_code_r <= cur_code_s;
      end else begin
        sweep_hit_r  <= sweep_hit_r;
      end
    end else begin
      scan_cnt_r <= scan_cnt_r + 32'd1;
    end
  end

  // Lock state machine with registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      password_input <= 12'h000;
      input_count    <= 3'd0;
      success_input  <= 1'b0;
      failure_times  <= 2'd0;
      stored_pw_r    <= 12'h000;
      pw_valid_r     <= 1'b0;
      timer_r        <= 32'd0;
      set_q_r        <= 1'b0;
      confirm_q_r    <= 1'b0;
      clear_q_r      <= 1'b0;
    end else begin
      set_q_r     <= key_set;
      confirm_q_r <= key_confirm;
      clear_q_r   <= key_clear;
      // Timed states override this; any state change therefore restarts the timer.
      timer_r     <= 32'd0;
      if (release_s) begin
        success_input <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (set_edge_s) begin
            state_r        <= SETTING_CODE;
            password_input <= 12'h000;
            input_count    <= 3'd0;
          end else if (digit_ok_s && pw_valid_r) begin
            state_r        <= INPUTING_PASSWORD;
            password_input <= {end_code_s, 8'h00};
            input_count    <= 3'd1;
            success_input  <= 1'b1;
          end
        end
        SETTING_CODE: begin
          if (set_edge_s || clear_edge_s) begin
            password_input <= 12'h000;
            input_count    <= 3'd0;
          end else if (confirm_edge_s) begin
            if (input_count == 3'd3) begin
              stored_pw_r    <= password_input;
              pw_valid_r     <= 1'b1;
              failure_times  <= 2'd0;
              state_r        <= SETCODE_FINISH;
              password_input <= 12'h000;
              input_count    <= 3'd0;
            end
          end else if (digit_ok_s && can_write_s) begin
            password_input <= buf_next_s;
            input_count    <= input_count + 3'd1;
            success_input  <= 1'b1;
          end
        end
        INPUTING_PASSWORD: begin
          if (clear_edge_s) begin
            password_input <= 12'h000;
            input_count    <= 3'd0;
          end else if (confirm_edge_s) begin
            if (input_count == 3'd3) begin
              password_input <= 12'h000;
              input_count    <= 3'd0;
              if (password_input == stored_pw_r) begin
                state_r       <= MATCH_SUCCESS;
                failure_times <= 2'd0;
              end else if (failure_times >= 2'd2) begin
                state_r       <= FREEZED;
                failure_times <= 2'd3;
              end else begin
                state_r       <= IDLE;
                failure_times <= failure_times + 2'd1;
              end
            end
          end else if (digit_ok_s && can_write_s) begin
            password_input <= buf_next_s;
            input_count    <= input_count + 3'd1;
            success_input  <= 1'b1;
          end
        end
        SETCODE_FINISH: begin
          if (timer_r == HOLD_LAST) begin
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end
        MATCH_SUCCESS: begin
          if (set_edge_s) begin
            state_r        <= SETTING_CODE;
            password_input <= 12'h000;
            input_count    <= 3'd0;
          end else if (timer_r == HOLD_LAST) begin
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end
        FREEZED: begin
          if (timer_r == FREEZE_LAST) begin
            state_r       <= IDLE;
            failure_times <= 2'd0;
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/password_entry_ctrl.md
# password_entry_ctrl

Producer side of the lock's display interface. Scans a 4x4 hex keypad, debounces presses, and runs the lock state machine (set password, enter password, match, freeze). It drives `password_input`, `input_count`, `success_input`, `current_work_state` and `failure_times` to the display driver. `clk` is the board clock; one column dwell equals one display digit refresh period.

## Interface
- `SCAN_TICKS`, default 200_000: cycles per keypad column dwell. Simulation uses 2.
- `HOLD_TICKS`, default 100_000_000: cycles spent in `SETCODE_FINISH` and `MATCH_SUCCESS`.
- `FREEZE_TICKS`, default 500_000_000: cycles spent in `FREEZED`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock, no other clock domains.
- `row_in`  in  4  keypad rows, active-low, already synchronised.
- `col_out`  out  4  keypad column drive, active-low one-cold.
- `key_set`  in  1  "set password" button, debounced level.
- `key_confirm`  in  1  "confirm" button, debounced level.
- `key_clear`  in  1  "clear entry" button, debounced level.
- `password_input`  out  12  entry buffer; first digit in [11:8], second in [7:4], third in [3:0].
- `input_count`  out  3  digits entered, 0..3.
- `success_input`  out  1  high from digit acceptance until that key is released.
- `current_work_state`  out  3  IDLE=000, SETTING_CODE=001, SETCODE_FINISH=010, INPUTING_PASSWORD=011, MATCH_SUCCESS=100, FREEZED=101.
- `failure_times`  out  2  consecutive failed matches, 0..3.

## Operation
- **Reset values:**
  - `col_out`=1110, `password_input`=0, `input_count`=0, `success_input`=0.
  - state IDLE, `failure_times`=0.
  - internal `stored_pw`=0, `pw_valid`=0, timers 0.
- **Scan:**
  - `col_out` rotates 1110→1101→1011→0111→1110, advancing every `SCAN_TICKS` cycles.
  - `row_in` is sampled on the last cycle of each dwell.
  - Key code = {row index, column index}, where row index is the lowest i with `row_in[i]`=0.
  - Within one 4-column sweep, the first detected key (earliest column) wins; others are ignored.
- **Debounce:**
  - A digit is accepted when the same code is seen in two consecutive sweeps and no key was accepted since the last key-free sweep.
  - A full sweep with no key = released; `success_input` drops at the end of that sweep.
  - Holding a key yields exactly one acceptance.
- **Function buttons:**
  - Rising-edge detected internally (previous-cycle register).
  - Priority within a cycle: set > clear > confirm > digit.
- **Digit write:** writes nibble at position `input_count`, then count+1. A digit at count=3 is ignored and `success_input` is not raised.
- **Transitions:**
  - **IDLE:**
    - set edge → SETTING_CODE; buffer and count cleared.
    - Accepted digit with `pw_valid`=1 → INPUTING_PASSWORD with that digit written (count=1).
    - Digits with `pw_valid`=0 are ignored.
  - **SETTING_CODE:**
    - clear → buffer and count zeroed.
    - confirm at count=3 → `stored_pw`←buffer, `pw_valid`←1, `failure_times`←0, SETCODE_FINISH, buffer and count cleared.
    - confirm at count<3 → ignored.
  - **INPUTING_PASSWORD:**
    - clear → as above.
    - confirm at count=3, buffer equal to `stored_pw` → MATCH_SUCCESS, `failure_times`←0.
    - confirm at count=3, mismatch → `failure_times`+1. If the new value is 3 → FREEZED, otherwise → IDLE.
    - Buffer and count are cleared in both match and mismatch cases.
    - set edge → ignored.
  - **SETCODE_FINISH:** after `HOLD_TICKS` cycles → IDLE.
  - **MATCH_SUCCESS:** after `HOLD_TICKS` cycles → IDLE; a set edge here → SETTING_CODE immediately.
  - **FREEZED:**
    - All keys and buttons ignored.
    - After `FREEZE_TICKS` cycles → IDLE with `failure_times`←0.
- **Timers and counters:**
  - Timers count 0..N-1 and exit on N-1; they are cleared on every state entry.
  - `failure_times` never wraps past 3.
- Keypad scanning continues in every state; debounce state persists across state changes.

## Timing
- All outputs are registered.
- Button edge: `key_*` high at cycle N (low at N-1) → state/outputs updated at cycle N+1.
- Digit: accepted on the sample cycle of the second matching sweep. `password_input`, `input_count` and `success_input` update the next cycle.
- Hold exit: state changes exactly `HOLD_TICKS` cycles after entry (respectively `FREEZE_TICKS` for FREEZED).
- A set edge and a hold expiry in the same cycle: set wins (in MATCH_SUCCESS).
- Reset mid-operation: all registers return to reset values on the next edge, including `stored_pw` and `pw_valid`.

## Test plan
Parameters for all scenarios: `SCAN_TICKS`=2, `HOLD_TICKS`=8, `FREEZE_TICKS`=16.

- **Scan rotation:** after reset, `col_out` reads 1110,1110,1101,1101,1011,… → rotation every 2 cycles, wraps to 1110 after 0111.
- **Set password:**
  - Pulse `key_set`, press keys 1, A, 7 (each held 3 sweeps, released 2 sweeps), pulse `key_confirm`.
  - Required: `password_input` 0x100→0x1A0→0x1A7, `input_count` 1→2→3, `success_input` high during each press.
  - Then state 010 for 8 cycles, then 000.
- **Match:** after the set, enter 1,A,7 + confirm → state 011 after the first digit, then 100; `failure_times`=0; IDLE 8 cycles later.
- **Freeze:**
  - Three wrong entries (0,0,0 + confirm): `failure_times` 1,2,3, state ends 101.
  - Keypresses during freeze do not change outputs.
  - After 16 cycles, state 000 and `failure_times`=0.
- **Boundaries:**
  - Confirm at count=2 → ignored.
  - 4th digit → ignored.
  - Clear and confirm in the same cycle → buffer 0, no match attempt.
  - Digit in IDLE before any set → ignored.
- **Reset mid-entry:** assert `reset` with count=2 in INPUTING_PASSWORD → next cycle all outputs at reset values, `pw_valid`=0.
